mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Core-side initiator for the memory/IO port. Accepts one load/store at a time from
//  the pipeline's MEM stage and drives order/io/address/i_data toward the memory
//  responder. Waits for accepted, then accessed, then returns read data or completion
//  to the pipeline. Bounds every access with a timeout counter.
// PARAMETERS
//  TIMEOUT_CYCLES  1023  cycles spent in ISSUE+WAIT before abort; 0 disables timeout
//  CNT_W           10    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1              clock; all logic on rising edge
//  rst          in   1              synchronous reset, active-high
//  req_valid    in   1              pipeline request valid
//  req_ready    out  1              controller can take a request (IDLE only)
//  req_store    in   1              1 = store, 0 = load
//  req_addr     in   `LEN_MEM_ADDR  byte address
//  req_wdata    in   `LEN_WORD      store data
//  resp_valid   out  1              one-cycle completion pulse
//  resp_rdata   out  `LEN_WORD      load data; valid with resp_valid on a load
//  resp_err     out  1              qualifies resp_valid: access aborted
//  busy         out  1              high in ISSUE, WAIT or RESP
//  order        out  1              to memory: request strobe
//  io           out  1              to memory: 1 = write, 0 = read
//  address      out  `LEN_MEM_ADDR  to memory: address
//  i_data       out  `LEN_WORD      to memory: write data
//  accepted     in   1              from memory: request taken this cycle
//  accessed     in   1              from memory: access complete this cycle; o_data valid on read
//  o_data       in   `LEN_WORD      from memory: read data
// BEHAVIOUR
//  - All outputs registered except req_ready (= state==IDLE).
//  - Reset values: order=0, io=0, address=0, i_data=0, resp_valid=0, resp_err=0,
//    resp_rdata=0, busy=0, state=IDLE, counter=0.
//  - FSM states: IDLE, ISSUE, WAIT, RESP.
//  - IDLE: on req_valid, latch store/addr/wdata into io/address/i_data, set order=1,
//    clear counter, go to ISSUE. Requests are ignored in every other state.
//  - ISSUE: order held at 1; address, io and i_data stay stable.
//      - accepted & accessed: order=0, go to RESP (capture o_data if load).
//      - accepted only: order=0, go to WAIT.
//      - accessed without accepted: ignored.
//  - WAIT: order=0. On accessed, go to RESP and capture o_data into resp_rdata if load.
//  - RESP: resp_valid=1 for exactly one cycle, then IDLE. The pipeline has no
//    backpressure and must sample it.
//  - Timeout: counter increments every cycle in ISSUE and WAIT.
//      - When counter reaches TIMEOUT_CYCLES-1 with no completing event, order=0,
//        go to RESP with resp_err=1.
//      - If completion and expiry fall in the same cycle, completion wins (resp_err=0).
//  - resp_rdata updates only on a successful load and holds otherwise. resp_err clears
//    on leaving RESP.
//  - Min latency: request in cycle N, order in N+1, resp_valid in N+2 when the memory
//    asserts accepted and accessed together. Next request is taken at N+3.
//  - Reset mid-access: next edge returns to IDLE with order=0; the outstanding access
//    is dropped and no resp_valid is produced.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//    - IDLE request with req_addr[1:0] != 2'b00 is not issued; order stays 0.
//    - FSM goes directly to RESP with resp_err=1 (latency 1: resp_valid in N+1).
//  MEM_ALIGN_CHECK_EN undefined: the address is passed through unchecked.
// TESTING
//  1. Load addr=0x100; memory asserts accepted+accessed in the first order cycle with
//     o_data=0xDEADBEEF -> resp_valid at N+2, resp_rdata=0xDEADBEEF, resp_err=0.
//  2. Store addr=0x40 wdata=0x12345678; accepted after 3 cycles, accessed 5 cycles
//     later -> io=1 and i_data stable while order=1, order falls after accepted,
//     one resp_valid pulse, resp_rdata unchanged.
//  3. TIMEOUT_CYCLES=8, memory never accepts -> order high 8 cycles then 0,
//     resp_valid=1 with resp_err=1, req_ready the cycle after.
//  4. accessed pulse while in ISSUE without accepted -> ignored, stays in ISSUE;
//     later accepted+accessed completes normally.
//  5. rst=1 while in WAIT -> next cycle order=0, busy=0, req_ready=1, no resp_valid;
//     a new load then completes normally.
//  6. With MEM_ALIGN_CHECK_EN, load addr=0x102 -> order never asserts,
//     resp_valid+resp_err at N+1.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store initiator from the MEM stage toward the memory/IO responder.
// Latency: request in N, order in N+1, resp_valid at N+2 at best; every access is bounded by TIMEOUT_CYCLES.
// Backpressure: req_ready only in IDLE; resp_valid is a one-cycle pulse the pipeline must sample.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned requests are answered with resp_err and never issued.

`ifndef LEN_MEM_ADDR
`define LEN_MEM_ADDR 32
`endif
`ifndef LEN_WORD
`define LEN_WORD 32
`endif

module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_W          = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  // pipeline side
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [`LEN_MEM_ADDR-1:0] req_addr,
  input  logic [`LEN_WORD-1:0]     req_wdata,
  output logic                     resp_valid,
  output logic [`LEN_WORD-1:0]     resp_rdata,
  output logic                     resp_err,
  output logic                     busy,
  // memory side
  output logic                     order,
  output logic                     io,
  output logic [`LEN_MEM_ADDR-1:0] address,
  output logic [`LEN_WORD-1:0]     i_data,
  input  logic                     accepted,
  input  logic                     accessed,
  input  logic [`LEN_WORD-1:0]     o_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  // Counter value on the last permitted ISSUE/WAIT cycle; a zero TIMEOUT_CYCLES disables expiry.
  localparam int unsigned      TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_LAST_I);
  localparam bit               TO_EN     = (TIMEOUT_CYCLES != 0);

  state_e                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [CNT_W-1:0]           cnt_d;
  logic                       order_q;
  logic                       io_q;
  logic [`LEN_MEM_ADDR-1:0]   address_q;
  logic [`LEN_WORD-1:0]       i_data_q;
  logic                       resp_valid_q;
  logic                       resp_err_q;
  logic [`LEN_WORD-1:0]       resp_rdata_q;
  logic                       busy_q;
  logic                       timeout_hit;
  logic                       misaligned;

  assign cnt_d       = cnt_q + 1'b1;
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign req_ready  = (state_q == S_IDLE);
  assign order      = order_q;
  assign io         = io_q;
  assign address    = address_q;
  assign i_data     = i_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign busy       = busy_q;

  // Access sequencer: state, memory strobes, timeout counter and registered pipeline response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      order_q      <= 1'b0;
      io_q         <= 1'b0;
      address_q    <= '0;
      i_data_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            busy_q <= 1'b1;
            if (misaligned) begin
              // Rejected without touching the memory port.
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              io_q      <= req_store;
              address_q <= req_addr;
              i_data_q  <= req_wdata;
              order_q   <= 1'b1;
              cnt_q     <= '0;
              state_q   <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (accepted && accessed) begin
            // Completion beats a coincident expiry.
            order_q      <= 1'b0;
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            if (!io_q) resp_rdata_q <= o_data;
          end else if (timeout_hit) begin
            order_q      <= 1'b0;
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else if (accepted) begin
            order_q <= 1'b0;
            state_q <= S_WAIT;
            cnt_q   <= cnt_d;
          end else begin
            // A lone accessed pulse here belongs to nobody and is ignored.
            cnt_q <= cnt_d;
          end
        end

        S_WAIT: begin
          if (accessed) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            if (!io_q) resp_rdata_q <= o_data;
          end else if (timeout_hit) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_RESP: begin
          // Response pulse lasts exactly this one cycle.
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          order_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
